// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one write-through data cache between instruction fetch
// (port 0) and load/store (port 1); sequences the cache via MFCreset/MFC with a watchdog.
module cache_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] cache_addr,
  output logic [DW-1:0] cache_datain,
  output logic          cache_read_en,
  output logic          cache_write_en,
  output logic          cache_enable,
  output logic          cache_mfc_reset,
  input  logic          cache_mfc,
  input  logic [DW-1:0] cache_dataout,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    wdog;
  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Round-robin only matters on a tie; a lone requester always wins.
  assign win       = (req0 && req1) ? ~grant_id : req1;
  assign win_we    = win ? we1 : we0;
  assign win_addr  = win ? addr1 : addr0;
  assign win_wdata = win ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state           <= S_IDLE;
      wdog            <= '0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      err0            <= 1'b0;
      err1            <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
      cache_addr      <= '0;
      cache_datain    <= '0;
      cache_read_en   <= 1'b0;
      cache_write_en  <= 1'b0;
      cache_enable    <= 1'b0;
      cache_mfc_reset <= 1'b1;
      busy            <= 1'b0;
      grant_id        <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        S_IDLE: begin
          cache_mfc_reset <= 1'b1;
          if (req0 || req1) begin
            // Cache lines are frozen here because the cache samples addr in several states.
            state          <= S_ISSUE;
            grant_id       <= win;
            cache_addr     <= win_addr;
            cache_datain   <= win_wdata;
            cache_read_en  <= ~win_we;
            cache_write_en <= win_we;
            cache_enable   <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_ISSUE: begin
          state           <= S_SETTLE;
          cache_mfc_reset <= 1'b0;
        end
        S_SETTLE: begin
          // MFC may still be high from the previous access, so it is not looked at yet.
          state <= S_WAIT;
          wdog  <= '0;
        end
        S_WAIT: begin
          wdog <= wdog + 8'd1;
          if (cache_mfc) begin
            state <= S_DONE;
            if (grant_id) begin
              ack1 <= 1'b1;
              if (!cache_write_en) rdata1 <= cache_dataout;
            end else begin
              ack0 <= 1'b1;
              if (!cache_write_en) rdata0 <= cache_dataout;
            end
            cache_mfc_reset <= 1'b1;
            cache_enable    <= 1'b0;
            cache_read_en   <= 1'b0;
            cache_write_en  <= 1'b0;
          end else if (wdog == WD_LAST) begin
            state <= S_ABORT;
            if (grant_id) err1 <= 1'b1;
            else          err0 <= 1'b1;
            cache_mfc_reset <= 1'b1;
            cache_enable    <= 1'b0;
            cache_read_en   <= 1'b0;
            cache_write_en  <= 1'b0;
          end
        end
        S_DONE, S_ABORT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
